// File: rtl/xy_switch_alloc.sv
`default_nettype none
// ============================================================================
// Module   : xy_switch_alloc
// Brief    : XY route compute, per-output round-robin allocation with credit
//            flow control, and registered crossbar outputs.
// Revision : 1.0
// ============================================================================
module xy_switch_alloc #(
    parameter  int N_PORT     = 5,
    parameter  int DATA_WIDTH = 8,
    parameter  int ADDR_WIDTH = 3,
    parameter  int MY_X       = 0,
    parameter  int MY_Y       = 0,
    parameter  int CREDITS    = 4,
    localparam int FW         = DATA_WIDTH + 2 * ADDR_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [N_PORT-1:0][FW-1:0]           in_data_i,
    input  logic [N_PORT-1:0]                   in_empty_i,
    input  logic [N_PORT-1:0][ADDR_WIDTH-1:0]   in_x_dest_i,
    input  logic [N_PORT-1:0][ADDR_WIDTH-1:0]   in_y_dest_i,
    output logic [N_PORT-1:0]                   rd_en_o,
    output logic [N_PORT-1:0][FW-1:0]           out_data_o,
    output logic [N_PORT-1:0]                   out_valid_o,
    input  logic [N_PORT-1:0]                   credit_in_i,
    output logic                                credit_err_o
);

    localparam int PW = (N_PORT > 1) ? $clog2(N_PORT) : 1;
    localparam int CW = $clog2(CREDITS + 1);

    localparam logic [PW-1:0]         c_LOCAL    = PW'(0);
    localparam logic [PW-1:0]         c_NORTH    = PW'(1);
    localparam logic [PW-1:0]         c_EAST     = PW'(2);
    localparam logic [PW-1:0]         c_SOUTH    = PW'(3);
    localparam logic [PW-1:0]         c_WEST     = PW'(4);
    localparam logic [PW-1:0]         c_LAST     = PW'(N_PORT - 1);
    localparam logic [ADDR_WIDTH-1:0] c_MY_X     = ADDR_WIDTH'(MY_X);
    localparam logic [ADDR_WIDTH-1:0] c_MY_Y     = ADDR_WIDTH'(MY_Y);
    localparam logic [CW-1:0]         c_CRED_MAX = CW'(CREDITS);

    logic [N_PORT-1:0][PW-1:0] w_route;
    logic [N_PORT-1:0]         w_gnt;
    logic [N_PORT-1:0][PW-1:0] w_win;
    logic [N_PORT-1:0]         w_ovf;
    logic                      credit_err_q;

    // X is resolved before Y; each non-empty input requests exactly one output.
    always_comb begin
        for (int i = 0; i < N_PORT; i++) begin
            if (in_x_dest_i[i] > c_MY_X)      w_route[i] = c_EAST;
            else if (in_x_dest_i[i] < c_MY_X) w_route[i] = c_WEST;
            else if (in_y_dest_i[i] > c_MY_Y) w_route[i] = c_NORTH;
            else if (in_y_dest_i[i] < c_MY_Y) w_route[i] = c_SOUTH;
            else                              w_route[i] = c_LOCAL;
        end
    end

    generate
        for (genvar o = 0; o < N_PORT; o++) begin : g_out
            logic [N_PORT-1:0] w_elig;
            logic              w_gnt_l;
            logic [PW-1:0]     w_win_l;
            logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
            logic [CW-1:0]     credit_q, credit_d;
            logic              gnt_v_q;
            logic [PW-1:0]     gnt_idx_q;
            logic              out_v_q;
            logic [FW-1:0]     out_d_q;

            always_comb begin
                for (int i = 0; i < N_PORT; i++) begin
                    w_elig[i] = rst && !in_empty_i[i] && (w_route[i] == PW'(o))
                                && (credit_q != '0);
                end
            end

            always_comb begin
                logic [PW-1:0] idx;
                idx     = '0;
                w_gnt_l = 1'b0;
                w_win_l = '0;
                for (int k = 0; k < N_PORT; k++) begin
                    idx = PW'((int'(rr_ptr_q) + k) % N_PORT);
                    if (!w_gnt_l && w_elig[idx]) begin
                        w_gnt_l = 1'b1;
                        w_win_l = idx;
                    end
                end
            end

            always_comb begin
                rr_ptr_d = rr_ptr_q;
                if (w_gnt_l) rr_ptr_d = (w_win_l == c_LAST) ? '0 : w_win_l + PW'(1);
                credit_d = credit_q;
                if (credit_in_i[o] && !w_gnt_l && (credit_q != c_CRED_MAX))
                    credit_d = credit_q + CW'(1);
                else if (w_gnt_l && !credit_in_i[o])
                    credit_d = credit_q - CW'(1);
            end

            assign w_gnt[o]       = w_gnt_l;
            assign w_win[o]       = w_win_l;
            assign w_ovf[o]       = credit_in_i[o] && !w_gnt_l && (credit_q == c_CRED_MAX);
            assign out_valid_o[o] = out_v_q;
            assign out_data_o[o]  = out_d_q;

            // The popped flit appears on in_data one cycle after the grant.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    rr_ptr_q  <= '0;
                    credit_q  <= c_CRED_MAX;
                    gnt_v_q   <= 1'b0;
                    gnt_idx_q <= '0;
                    out_v_q   <= 1'b0;
                    out_d_q   <= '0;
                end else begin
                    rr_ptr_q  <= rr_ptr_d;
                    credit_q  <= credit_d;
                    gnt_v_q   <= w_gnt_l;
                    gnt_idx_q <= w_win_l;
                    out_v_q   <= gnt_v_q;
                    if (gnt_v_q) out_d_q <= in_data_i[gnt_idx_q];
                end
            end
        end
    endgenerate

    always_comb begin
        rd_en_o = '0;
        for (int o = 0; o < N_PORT; o++) begin
            if (w_gnt[o]) rd_en_o[w_win[o]] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)        credit_err_q <= 1'b0;
        else if (|w_ovf) credit_err_q <= 1'b1;
    end

    assign credit_err_o = credit_err_q;

endmodule
`default_nettype wire

// File: tb/tb_xy_switch_alloc.sv
`default_nettype none
// ============================================================================
// Module   : tb_xy_switch_alloc
// Brief    : Self-checking bench for xy_switch_alloc (router at X=2, Y=2).
// Revision : 1.0
// ============================================================================
module tb_xy_switch_alloc;

    localparam int NP   = 5;
    localparam int DW   = 8;
    localparam int AW   = 3;
    localparam int FW   = DW + 2 * AW;
    localparam int CRED = 4;
    localparam int MYX  = 2;
    localparam int MYY  = 2;

    typedef logic [FW-1:0] flit_t;
    typedef struct {
        int         x;
        int         y;
        logic [7:0] d;
        int         port;
    } route_vec_t;

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic [NP-1:0][FW-1:0]    in_data = '0;
    logic [NP-1:0]            in_empty = '1;
    logic [NP-1:0][AW-1:0]    in_x = '0;
    logic [NP-1:0][AW-1:0]    in_y = '0;
    logic [NP-1:0]            rd_en;
    logic [NP-1:0][FW-1:0]    out_data;
    logic [NP-1:0]            out_valid;
    logic [NP-1:0]            credit_in = '0;
    logic                     credit_err;

    xy_switch_alloc #(
        .N_PORT(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .MY_X(MYX), .MY_Y(MYY), .CREDITS(CRED)
    ) dut (
        .clk(clk), .rst(rst),
        .in_data_i(in_data), .in_empty_i(in_empty),
        .in_x_dest_i(in_x), .in_y_dest_i(in_y),
        .rd_en_o(rd_en), .out_data_o(out_data), .out_valid_o(out_valid),
        .credit_in_i(credit_in), .credit_err_o(credit_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    flit_t                 q [NP][$];
    int                    n_chk = 0;
    int                    n_pass = 0;
    logic [NP-1:0]         s_rd, s_ov;
    logic [NP-1:0][FW-1:0] s_od;
    logic                  s_err;

    // Reference model state for the randomized phase
    bit                    model_on = 1'b0;
    int                    m_cred [NP];
    int                    m_ptr [NP];
    logic [NP-1:0]         ea_v, eb_v;
    flit_t                 ea_d [NP];
    flit_t                 eb_d [NP];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    function automatic flit_t mk_flit(input int x, input int y, input logic [7:0] d);
        return {3'(y), 3'(x), d};
    endfunction

    function automatic int route_of(input flit_t f);
        int x, y;
        x = int'(f[10:8]);
        y = int'(f[13:11]);
        if (x > MYX) return 2;
        if (x < MYX) return 4;
        if (y > MYY) return 1;
        if (y < MYY) return 3;
        return 0;
    endfunction

    task automatic refresh();
        flit_t h;
        for (int i = 0; i < NP; i++) begin
            if (q[i].size() > 0) begin
                h = q[i][0];
                in_empty[i] = 1'b0;
                in_x[i]     = h[10:8];
                in_y[i]     = h[13:11];
            end else begin
                in_empty[i] = 1'b1;
                in_x[i]     = 3'($urandom);
                in_y[i]     = 3'($urandom);
            end
        end
    endtask

    task automatic model_step();
        logic [NP-1:0] exp_rd, cur_v;
        flit_t         cur_d [NP];
        int            best, bestd, d;
        exp_rd = '0;
        cur_v  = '0;
        chk("rand_out_valid", 32'(s_ov), 32'(ea_v));
        for (int o = 0; o < NP; o++) begin
            cur_d[o] = '0;
            if (ea_v[o]) chk("rand_out_data", 32'(s_od[o]), 32'(ea_d[o]));
        end
        for (int o = 0; o < NP; o++) begin
            best  = -1;
            bestd = NP;
            if (m_cred[o] > 0) begin
                for (int i = 0; i < NP; i++) begin
                    if (q[i].size() > 0 && route_of(q[i][0]) == o) begin
                        d = (i - m_ptr[o] + NP) % NP;
                        if (d < bestd) begin
                            bestd = d;
                            best  = i;
                        end
                    end
                end
            end
            if (best >= 0) begin
                exp_rd[best] = 1'b1;
                cur_v[o]     = 1'b1;
                cur_d[o]     = q[best][0];
                m_ptr[o]     = (best + 1) % NP;
            end
            m_cred[o] = m_cred[o] + (credit_in[o] ? 1 : 0) - (best >= 0 ? 1 : 0);
        end
        chk("rand_rd_en", 32'(s_rd), 32'(exp_rd));
        ea_v = eb_v;
        ea_d = eb_d;
        eb_v = cur_v;
        eb_d = cur_d;
    endtask

    // One clock: sample at the falling edge, then model FIFO pops after the rising edge.
    task automatic tick();
        @(negedge clk);
        s_rd  = rd_en;
        s_ov  = out_valid;
        s_od  = out_data;
        s_err = credit_err;
        if (model_on) model_step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NP; i++) begin
            if (s_rd[i] && q[i].size() > 0) in_data[i] = q[i].pop_front();
        end
        refresh();
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        credit_in = '0;
        for (int i = 0; i < NP; i++) q[i].delete();
        refresh();
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        route_vec_t    rv [5];
        flit_t         f, od;
        int            r, v, n_rd, n_ov, n_push, n_deliv;
        int            pending [NP];
        int            order [3];
        logic [NP-1:0] ov, acc, first;
        logic [7:0]    pat;

        rv[0] = '{3, 2, 8'hA5, 2};
        rv[1] = '{1, 2, 8'h5A, 4};
        rv[2] = '{2, 3, 8'h3C, 1};
        rv[3] = '{2, 1, 8'hC3, 3};
        rv[4] = '{2, 2, 8'h81, 0};
        order[0] = 1;
        order[1] = 3;
        order[2] = 4;

        // Reset state, with a waiting flit that must not be popped
        rst = 1'b0;
        q[0].push_back(mk_flit(3, 2, 8'h11));
        refresh();
        tick();
        tick();
        chk("reset_out_valid", 32'(s_ov), 32'h0);
        chk("reset_out_data", 32'(s_od != '0), 32'h0);
        chk("reset_credit_err", 32'(s_err), 32'h0);
        chk("reset_rd_en", 32'(s_rd), 32'h0);
        q[0].delete();
        refresh();
        rst = 1'b1;

        // Table-driven routing from the Local input
        for (int t = 0; t < 5; t++) begin
            f  = mk_flit(rv[t].x, rv[t].y, rv[t].d);
            r  = -1;
            v  = -1;
            ov = '0;
            od = '0;
            q[0].push_back(f);
            refresh();
            for (int c = 0; c < 8; c++) begin
                tick();
                if (s_rd[0] && r < 0) r = c;
                if (s_ov != '0 && v < 0) begin
                    v  = c;
                    ov = s_ov;
                    od = s_od[rv[t].port];
                end
            end
            chk("route_latency", 32'(v - r), 32'd2);
            chk("route_port", 32'(ov), 32'(1 << rv[t].port));
            chk("route_data", 32'(od), 32'(f));
        end

        // Empty inputs with arbitrary coordinates never request
        acc = '0;
        for (int c = 0; c < 4; c++) begin
            tick();
            acc = acc | s_rd | s_ov;
        end
        chk("empty_no_request", 32'(acc), 32'h0);

        // Round-robin N,S,W into Local with a credit returned every grant cycle
        do_reset();
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 3; j++)
                q[order[k]].push_back(mk_flit(2, 2, 8'(order[k] * 16 + j)));
        refresh();
        for (int c = 0; c < 11; c++) begin
            credit_in[0] = (c < 9);
            tick();
            chk("rr_rd_en", 32'(s_rd), (c < 9) ? 32'(1 << order[c % 3]) : 32'h0);
            chk("rr_out_valid", 32'(s_ov), (c >= 2) ? 32'h1 : 32'h0);
            if (c >= 2)
                chk("rr_out_data", 32'(s_od[0]),
                    32'(mk_flit(2, 2, 8'(order[(c - 2) % 3] * 16 + (c - 2) / 3))));
        end
        credit_in = '0;
        chk("rr_no_credit_err", 32'(s_err), 32'h0);

        // Credit stall: six flits Local->East, no credits returned
        do_reset();
        for (int k = 0; k < 6; k++) q[0].push_back(mk_flit(3, 2, 8'(8'hC0 + k)));
        refresh();
        n_rd = 0;
        n_ov = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            n_rd += int'(s_rd[0]);
            n_ov += int'(s_ov[2]);
        end
        chk("stall_pops", 32'(n_rd), 32'd4);
        chk("stall_out_valid", 32'(n_ov), 32'd4);
        chk("stall_rd_held_low", 32'(s_rd[0]), 32'h0);
        credit_in[2] = 1'b1;
        tick();
        credit_in[2] = 1'b0;
        n_rd += int'(s_rd[0]);
        n_ov += int'(s_ov[2]);
        for (int c = 0; c < 7; c++) begin
            tick();
            n_rd += int'(s_rd[0]);
            n_ov += int'(s_ov[2]);
        end
        chk("stall_release_pops", 32'(n_rd), 32'd5);
        chk("stall_release_out_valid", 32'(n_ov), 32'd5);
        chk("stall_queue_left", 32'(q[0].size()), 32'd1);

        // Grant and credit return in the same cycle at credit=1
        do_reset();
        for (int k = 0; k < 6; k++) q[0].push_back(mk_flit(3, 2, 8'(8'hD0 + k)));
        refresh();
        pat = '0;
        for (int c = 0; c < 8; c++) begin
            credit_in[2] = (c == 3);
            tick();
            pat[c] = s_rd[0];
        end
        credit_in = '0;
        chk("simul_grant_credit_pattern", 32'(pat), 32'h1F);
        chk("simul_no_credit_err", 32'(s_err), 32'h0);

        // Credit overflow is sticky until reset
        do_reset();
        credit_in[1] = 1'b1;
        tick();
        credit_in[1] = 1'b0;
        tick();
        chk("ovf_err_set", 32'(s_err), 32'h1);
        tick();
        tick();
        chk("ovf_err_sticky", 32'(s_err), 32'h1);
        rst = 1'b0;
        tick();
        tick();
        chk("ovf_err_cleared", 32'(s_err), 32'h0);
        rst = 1'b1;

        // Reset in the cycle after a grant
        do_reset();
        q[0].push_back(mk_flit(3, 2, 8'hE0));
        q[0].push_back(mk_flit(3, 2, 8'hE1));
        refresh();
        tick();
        chk("mid_grant", 32'(s_rd), 32'h1);
        rst = 1'b0;
        tick();
        chk("mid_rd_forced_low", 32'(s_rd), 32'h0);
        tick();
        chk("mid_out_valid_low", 32'(s_ov), 32'h0);
        for (int i = 0; i < NP; i++) q[i].delete();
        for (int k = 0; k < 5; k++) begin
            q[0].push_back(mk_flit(3, 2, 8'(8'hF0 + k)));
            q[4].push_back(mk_flit(3, 2, 8'(8'hF8 + k)));
        end
        refresh();
        rst   = 1'b1;
        first = '0;
        n_rd  = 0;
        n_ov  = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (first == '0) first = s_rd;
            n_rd += $countones(s_rd);
            n_ov += int'(s_ov[2]);
        end
        chk("mid_first_winner", 32'(first), 32'h1);
        chk("mid_credit_grants", 32'(n_rd), 32'd4);
        chk("mid_out_valid_count", 32'(n_ov), 32'd4);

        // Randomized traffic against the reference model
        do_reset();
        for (int o = 0; o < NP; o++) begin
            m_cred[o]  = CRED;
            m_ptr[o]   = 0;
            pending[o] = 0;
            ea_d[o]    = '0;
            eb_d[o]    = '0;
        end
        ea_v     = '0;
        eb_v     = '0;
        n_push   = 0;
        n_deliv  = 0;
        model_on = 1'b1;
        for (int c = 0; c < 380; c++) begin
            if (c < 300) begin
                for (int i = 0; i < NP; i++) begin
                    if (q[i].size() < 4 && $urandom_range(0, 2) == 0) begin
                        q[i].push_back(mk_flit($urandom_range(1, 3), $urandom_range(1, 3),
                                               8'($urandom)));
                        n_push++;
                    end
                end
            end
            for (int o = 0; o < NP; o++) begin
                credit_in[o] = (pending[o] > 0) && ($urandom_range(0, 2) != 0);
                if (credit_in[o]) pending[o]--;
            end
            refresh();
            tick();
            for (int o = 0; o < NP; o++) begin
                if (s_ov[o]) begin
                    pending[o]++;
                    n_deliv++;
                end
            end
        end
        model_on  = 1'b0;
        credit_in = '0;
        chk("rand_conservation", 32'(n_deliv), 32'(n_push));
        acc = '0;
        for (int i = 0; i < NP; i++) acc[i] = (q[i].size() != 0);
        chk("rand_queues_drained", 32'(acc), 32'h0);
        chk("rand_no_credit_err", 32'(s_err), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
